// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: button front end and heading controller for the snake game.
// Each of the four push buttons is synchronized and debounced. A fresh press
// becomes a candidate turn, and legal turns are queued until the next game Tick.
//
// Build option: define SNAKE_TURN_QUEUE_EN to hold pending turns in a 2-entry
// FIFO. When it is undefined, a single pending slot is used and a newer legal
// press overwrites the older one.
module snake_dir_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       Tick,
    input  logic       Clear,
    output logic [1:0] Dir,
    output logic       DirChanged,
    output logic [1:0] PendCount,
    output logic       Drop
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Button vectors are indexed as U=0, D=1, L=2, R=3, which is also the press priority order.
    logic [3:0]      btn_raw;
    logic [3:0]      btn_meta;
    logic [3:0]      btn_sync;
    logic [3:0]      db_level;
    logic [3:0]      db_prev;
    logic [3:0]      armed;
    logic [DB_W-1:0] db_cnt [4];
    logic [1:0]      sync_age;
    logic [3:0]      press;

    logic            press_any;
    dir_t            press_dir;
    dir_t            dir_ref;
    logic            push;
    logic            pop;

    dir_t            dir_q;
    logic [1:0]      pend_cnt;
    logic            dir_chg;
    logic            drop_q;
    dir_t            q_head;
`ifdef SNAKE_TURN_QUEUE_EN
    dir_t            q_tail;
`endif

    assign btn_raw = {BtnR, BtnL, BtnD, BtnU};

    // Synchronize the raw buttons, debounce each one, and arm edge detection only after a real release is seen.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            db_level <= '0;
            db_prev  <= '0;
            armed    <= '0;
            sync_age <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop sample its pre-edge value, so statement order here does not matter.
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            db_prev  <= db_level;
            // sync_age holds off arming until the synchronizer carries post-reset samples.
            if (!sync_age[1]) begin
                sync_age <= sync_age + 2'd1;
            end
            for (int i = 0; i < 4; i++) begin
                if (btn_sync[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i] <= btn_sync[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                // A button held through reset stays unarmed until it is seen released.
                if (sync_age[1] && !btn_sync[i] && !db_level[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign press = db_level & ~db_prev & armed;

    // Pick one press per cycle with U > D > L > R. Presses that lose the priority vote are discarded.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        press_any = 1'b1;
        press_dir = DIR_UP;
        if (press[0]) begin
            press_dir = DIR_UP;
        end else if (press[1]) begin
            press_dir = DIR_DOWN;
        end else if (press[2]) begin
            press_dir = DIR_LEFT;
        end else if (press[3]) begin
            press_dir = DIR_RIGHT;
        end else begin
            press_any = 1'b0;
        end
    end

    // The legality check compares against the heading the snake will have once the queue drains.
`ifdef SNAKE_TURN_QUEUE_EN
    assign dir_ref = (pend_cnt == 2'd2) ? q_tail :
                     (pend_cnt == 2'd1) ? q_head : dir_q;
`else
    assign dir_ref = dir_q;
`endif

    // Same-axis presses (bit1 equal) are either a repeat of the heading or a reversal, and both are rejected.
    assign push = press_any && (press_dir[1] != dir_ref[1]);
    assign pop  = Tick && (pend_cnt != 2'd0);

    // Heading and pending-turn storage. Clear outranks Tick and press. On Tick, the pop is applied before the push.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dir_q    <= DIR_RIGHT;
            pend_cnt <= 2'd0;
            dir_chg  <= 1'b0;
            drop_q   <= 1'b0;
            // NOTE: turn storage is cleared on reset even though pend_cnt already marks it empty, so nothing holds X out of reset.
            q_head   <= DIR_RIGHT;
`ifdef SNAKE_TURN_QUEUE_EN
            q_tail   <= DIR_RIGHT;
`endif
        end else if (Clear) begin
            dir_q    <= DIR_RIGHT;
            pend_cnt <= 2'd0;
            dir_chg  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            dir_chg <= pop;
            drop_q  <= 1'b0;
            if (pop) begin
                dir_q <= q_head;
            end
`ifdef SNAKE_TURN_QUEUE_EN
            case ({pop, push})
                2'b11: begin
                    if (pend_cnt == 2'd2) begin
                        q_head <= q_tail;
                        q_tail <= press_dir;
                    end else begin
                        q_head <= press_dir;
                    end
                end
                2'b10: begin
                    q_head   <= q_tail;
                    pend_cnt <= pend_cnt - 2'd1;
                end
                2'b01: begin
                    if (pend_cnt == 2'd0) begin
                        q_head   <= press_dir;
                        pend_cnt <= 2'd1;
                    end else if (pend_cnt == 2'd1) begin
                        q_tail   <= press_dir;
                        pend_cnt <= 2'd2;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end
                default: ;
            endcase
`else
            case ({pop, push})
                2'b11: q_head <= press_dir;
                2'b10: pend_cnt <= 2'd0;
                2'b01: begin
                    q_head   <= press_dir;
                    pend_cnt <= 2'd1;
                end
                default: ;
            endcase
`endif
        end
    end

    assign Dir        = dir_q;
    assign PendCount  = pend_cnt;
    assign DirChanged = dir_chg;
    assign Drop       = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DB_CYCLES=4. Inputs are driven and
// outputs are sampled on the falling clock edge. Expectations branch on
// SNAKE_TURN_QUEUE_EN in the same way the design does.
module tb_snake_dir_ctrl;

    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 4;

    localparam logic [3:0] B_U = 4'b0001;
    localparam logic [3:0] B_D = 4'b0010;
    localparam logic [3:0] B_L = 4'b0100;
    localparam logic [3:0] B_R = 4'b1000;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       BtnU, BtnD, BtnL, BtnR;
    logic       Tick, Clear;
    logic [1:0] Dir;
    logic       DirChanged;
    logic [1:0] PendCount;
    logic       Drop;

    int checks = 0;
    int errors = 0;
    int dc_count = 0;
    int drop_count = 0;

    typedef struct {
        string      name;
        logic [3:0] btn;
        bit         do_tick;
        logic [1:0] exp_dir;
        logic [1:0] exp_pend;
        int         exp_dc;
    } vec_t;

    vec_t vecs[10];

    snake_dir_ctrl #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .BtnU      (BtnU),
        .BtnD      (BtnD),
        .BtnL      (BtnL),
        .BtnR      (BtnR),
        .Tick      (Tick),
        .Clear     (Clear),
        .Dir       (Dir),
        .DirChanged(DirChanged),
        .PendCount (PendCount),
        .Drop      (Drop)
    );

    always #5 Clk = ~Clk;

    // Count one-cycle output pulses, sampled mid-cycle.
    always @(negedge Clk) begin
        if (DirChanged) dc_count++;
        if (Drop) drop_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        {BtnR, BtnL, BtnD, BtnU} = m;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Hold the buttons well past the debounce time, then release them and let the release debounce too.
    task automatic press(input logic [3:0] m);
        set_btns(m);
        cycles(10);
        set_btns(4'b0000);
        cycles(10);
    endtask

    task automatic tick();
        Tick = 1'b1;
        cycles(1);
        Tick = 1'b0;
        cycles(1);
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        cycles(1);
        Clear = 1'b0;
        cycles(1);
    endtask

    initial begin
        int dc0;
        int drop0;

        vecs[0] = '{"d_queue",    B_D,   1'b0, 2'b11, 2'd1, 0};
        vecs[1] = '{"d_tick",     4'b0,  1'b1, 2'b01, 2'd0, 1};
        vecs[2] = '{"u_opposite", B_U,   1'b1, 2'b01, 2'd0, 0};
        vecs[3] = '{"d_same",     B_D,   1'b1, 2'b01, 2'd0, 0};
        vecs[4] = '{"l_turn",     B_L,   1'b1, 2'b10, 2'd0, 1};
        vecs[5] = '{"r_opposite", B_R,   1'b1, 2'b10, 2'd0, 0};
        vecs[6] = '{"u_turn",     B_U,   1'b1, 2'b00, 2'd0, 1};
        vecs[7] = '{"r_turn",     B_R,   1'b1, 2'b11, 2'd0, 1};
        vecs[8] = '{"tick_empty", 4'b0,  1'b1, 2'b11, 2'd0, 0};
        vecs[9] = '{"l_opposite", B_L,   1'b0, 2'b11, 2'd0, 0};

        Reset = 1'b1;
        Tick  = 1'b0;
        Clear = 1'b0;
        set_btns(4'b0000);
        cycles(2);
        check("reset_dir", Dir, 2'b11);
        check("reset_pend", PendCount, 2'd0);
        check("reset_dirchanged", DirChanged, 1'b0);
        check("reset_drop", Drop, 1'b0);
        Reset = 1'b0;
        cycles(4);

        // Press latency: PendCount rises exactly 7 edges after BtnD goes high.
        set_btns(B_D);
        cycles(6);
        check("latency_before", PendCount, 2'd0);
        cycles(1);
        check("latency_after", PendCount, 2'd1);
        cycles(3);
        set_btns(4'b0000);
        cycles(10);
        dc0 = dc_count;
        tick();
        cycles(1);
        check("latency_tick_dir", Dir, 2'b01);
        check("latency_tick_pend", PendCount, 2'd0);
        check("latency_tick_dc", dc_count - dc0, 1);

        // Clear returns the heading to right.
        Clear = 1'b1;
        cycles(1);
        Clear = 1'b0;
        check("clear_dir", Dir, 2'b11);
        check("clear_pend", PendCount, 2'd0);
        cycles(1);

        // Table of single-press scenarios.
        for (int i = 0; i < 10; i++) begin
            dc0 = dc_count;
            if (vecs[i].btn != 4'b0000) press(vecs[i].btn);
            if (vecs[i].do_tick) tick();
            cycles(1);
            check({vecs[i].name, "_dir"}, Dir, vecs[i].exp_dir);
            check({vecs[i].name, "_pend"}, PendCount, vecs[i].exp_pend);
            check({vecs[i].name, "_dc"}, dc_count - dc0, vecs[i].exp_dc);
        end

        // A 3-cycle glitch is shorter than the debounce window.
        set_btns(B_U);
        cycles(3);
        set_btns(4'b0000);
        cycles(15);
        check("glitch_pend", PendCount, 2'd0);

        // U and L rise together: only U (higher priority) is queued, and there is no drop.
        drop0 = drop_count;
        press(B_U | B_L);
        check("simul_pend", PendCount, 2'd1);
        check("simul_drop", drop_count - drop0, 0);

        // Tick coincides with the cycle of a later L press event.
        set_btns(B_L);
        cycles(6);
        Tick = 1'b1;
        cycles(1);
        Tick = 1'b0;
        check("coinc_dir", Dir, 2'b00);
`ifdef SNAKE_TURN_QUEUE_EN
        check("coinc_pend", PendCount, 2'd1);
`else
        check("coinc_pend", PendCount, 2'd0);
`endif
        set_btns(4'b0000);
        cycles(10);
        tick();
        cycles(1);
`ifdef SNAKE_TURN_QUEUE_EN
        check("coinc_head_dir", Dir, 2'b10);
`else
        check("coinc_head_dir", Dir, 2'b00);
`endif
        check("coinc_drain_pend", PendCount, 2'd0);
        do_clear();

        // Press U, then L, then D with no Tick in between.
        drop0 = drop_count;
        press(B_U);
        press(B_L);
        press(B_D);
        cycles(1);
`ifdef SNAKE_TURN_QUEUE_EN
        check("full_pend", PendCount, 2'd2);
        check("full_drop", drop_count - drop0, 1);
        dc0 = dc_count;
        tick();
        cycles(1);
        check("full_tick1_dir", Dir, 2'b00);
        tick();
        cycles(1);
        check("full_tick2_dir", Dir, 2'b10);
        check("full_tick_dc", dc_count - dc0, 2);
`else
        check("slot_pend", PendCount, 2'd1);
        check("slot_drop", drop_count - drop0, 0);
        dc0 = dc_count;
        tick();
        cycles(1);
        check("slot_tick_dir", Dir, 2'b01);
        check("slot_tick_dc", dc_count - dc0, 1);
`endif
        check("full_drain_pend", PendCount, 2'd0);
        do_clear();

        // Clear outranks a same-cycle Tick.
        press(B_U);
        dc0 = dc_count;
        Tick  = 1'b1;
        Clear = 1'b1;
        cycles(1);
        Tick  = 1'b0;
        Clear = 1'b0;
        check("clear_tick_dir", Dir, 2'b11);
        check("clear_tick_pend", PendCount, 2'd0);
        cycles(1);
        check("clear_tick_dc", dc_count - dc0, 0);

        // Clear outranks a same-cycle press event, and that press is lost.
        set_btns(B_U);
        cycles(6);
        Clear = 1'b1;
        cycles(1);
        Clear = 1'b0;
        check("clear_press_pend", PendCount, 2'd0);
        set_btns(4'b0000);
        cycles(10);
        check("clear_press_later_pend", PendCount, 2'd0);

        // Async reset with turns pending and the heading away from right.
        press(B_U);
        tick();
        press(B_L);
`ifdef SNAKE_TURN_QUEUE_EN
        press(B_U);
        check("prereset_pend", PendCount, 2'd2);
`else
        check("prereset_pend", PendCount, 2'd1);
`endif
        check("prereset_dir", Dir, 2'b00);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_dir", Dir, 2'b11);
        check("async_reset_pend", PendCount, 2'd0);
        @(negedge Clk);
        Reset = 1'b0;
        cycles(4);

        // A button held through reset produces no press until it is released and pressed again.
        set_btns(B_U);
        cycles(3);
        Reset = 1'b1;
        cycles(2);
        Reset = 1'b0;
        cycles(15);
        check("held_reset_pend", PendCount, 2'd0);
        set_btns(4'b0000);
        cycles(10);
        press(B_U);
        check("repress_pend", PendCount, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
